// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues single-outstanding word reads to instruction memory
// and presents fetched {pc, instruction} pairs to decode through a 2-entry buffer.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instruction,
  output logic [31:0] pc_out,
  input  logic        instr_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] DROP = 2'd2;

  logic [1:0]  state_r, state_s;
  logic [31:0] fetch_pc_r, fetch_pc_s;
  logic        req_r, req_s;
  logic [31:0] addr_r, addr_s;
  logic        valid_r;
  logic [1:0]  count_r, count_s;
  logic [31:0] head_pc_r, head_pc_s, head_ins_r, head_ins_s;
  logic [31:0] tail_pc_r, tail_pc_s, tail_ins_r, tail_ins_s;

  logic        pop_s, ack_s, push_s, space_s;
  logic [31:0] target_s, next_pc_s;

  assign pop_s     = (count_r != 2'd0) && instr_ready;
  assign ack_s     = req_r && imem_ack;
  assign push_s    = (state_r == WAIT) && ack_s && !redirect;
  assign target_s  = {redirect_pc[31:2], 2'b00};
  assign next_pc_s = fetch_pc_r + 32'd4;
  // space is judged after this edge's push/pop, so a drain can restart fetch on the same edge
  assign space_s   = (count_s < 2'd2);

  assign imem_req    = req_r;
  assign imem_addr   = addr_r;
  assign instr_valid = valid_r;
  assign instruction = head_ins_r;
  assign pc_out      = head_pc_r;

  // Two-entry buffer update; head always holds the presented entry, zeros when empty
  always_comb begin
    count_s    = count_r;
    head_pc_s  = head_pc_r;
    head_ins_s = head_ins_r;
    tail_pc_s  = tail_pc_r;
    tail_ins_s = tail_ins_r;
    if (redirect) begin
      count_s    = 2'd0;
      head_pc_s  = 32'd0;
      head_ins_s = 32'd0;
      tail_pc_s  = 32'd0;
      tail_ins_s = 32'd0;
    end else begin
      case ({push_s, pop_s})
        2'b10: begin
          if (count_r == 2'd0) begin
            head_pc_s  = addr_r;
            head_ins_s = imem_rdata;
            count_s    = 2'd1;
          end else if (count_r == 2'd1) begin
            tail_pc_s  = addr_r;
            tail_ins_s = imem_rdata;
            count_s    = 2'd2;
          end else begin
            count_s = count_r;
          end
        end
        2'b01: begin
          if (count_r == 2'd2) begin
            head_pc_s  = tail_pc_r;
            head_ins_s = tail_ins_r;
            tail_pc_s  = 32'd0;
            tail_ins_s = 32'd0;
            count_s    = 2'd1;
          end else begin
            head_pc_s  = 32'd0;
            head_ins_s = 32'd0;
            count_s    = 2'd0;
          end
        end
        2'b11: begin
          if (count_r == 2'd2) begin
            head_pc_s  = tail_pc_r;
            head_ins_s = tail_ins_r;
            tail_pc_s  = addr_r;
            tail_ins_s = imem_rdata;
          end else begin
            head_pc_s  = addr_r;
            head_ins_s = imem_rdata;
          end
        end
        default: begin
          count_s = count_r;
        end
      endcase
    end
  end

  // Request state machine: fetch_pc tracks the address of the current or next request
  always_comb begin
    state_s    = state_r;
    fetch_pc_s = fetch_pc_r;
    req_s      = req_r;
    addr_s     = addr_r;
    case (state_r)
      IDLE: begin
        if (redirect) begin
          state_s    = WAIT;
          req_s      = 1'b1;
          addr_s     = target_s;
          fetch_pc_s = target_s;
        end else if (space_s) begin
          state_s = WAIT;
          req_s   = 1'b1;
          addr_s  = fetch_pc_r;
        end else begin
          req_s = 1'b0;
        end
      end
      WAIT: begin
        if (ack_s) begin
          if (redirect) begin
            req_s      = 1'b1;
            addr_s     = target_s;
            fetch_pc_s = target_s;
          end else begin
            fetch_pc_s = next_pc_s;
            if (space_s) begin
              req_s  = 1'b1;
              addr_s = next_pc_s;
            end else begin
              state_s = IDLE;
              req_s   = 1'b0;
            end
          end
        end else if (redirect) begin
          // old request must still complete on the bus; its data is dropped later
          state_s    = DROP;
          fetch_pc_s = target_s;
        end else begin
          state_s = WAIT;
        end
      end
      DROP: begin
        if (ack_s) begin
          state_s    = WAIT;
          req_s      = 1'b1;
          addr_s     = redirect ? target_s : fetch_pc_r;
          fetch_pc_s = redirect ? target_s : fetch_pc_r;
        end else if (redirect) begin
          fetch_pc_s = target_s;
        end else begin
          state_s = DROP;
        end
      end
      default: begin
        state_s = IDLE;
        req_s   = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r    <= IDLE;
      fetch_pc_r <= RESET_PC;
      req_r      <= 1'b0;
      addr_r     <= 32'd0;
      valid_r    <= 1'b0;
      count_r    <= 2'd0;
      head_pc_r  <= 32'd0;
      head_ins_r <= 32'd0;
      tail_pc_r  <= 32'd0;
      tail_ins_r <= 32'd0;
    end else begin
      state_r    <= state_s;
      fetch_pc_r <= fetch_pc_s;
      req_r      <= req_s;
      addr_r     <= addr_s;
      valid_r    <= (count_s != 2'd0);
      count_r    <= count_s;
      head_pc_r  <= head_pc_s;
      head_ins_r <= head_ins_s;
      tail_pc_r  <= tail_pc_s;
      tail_ins_r <= tail_ins_s;
    end
  end

endmodule
